ramdp_mbox_ctrl: RTL
====================

Name: ramdp_mbox_ctrl

Overview:
- Mailbox controller that sequences ownership of the 8 KB MCU/CPU dual-port buffer.
- CPU fills the buffer and rings a doorbell; the controller hands the buffer to the MCU, tracks progress, and returns it with a response code and flags.
- Sits beside the dual-port buffer; gates CPU buffer writes and raises the MCU command interrupt.

Parameters:
- TIMEOUT_CYC, 50000000, clk cycles allowed in PEND+BUSY before forced completion; 0 disables the timeout.
- TO_W, 26, timeout counter width; must hold TIMEOUT_CYC.
- BUF_BYTES, 8192, buffer size; CPU LEN writes are clamped to this value.

Ports:
- clk  in  1  MCU clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- cpu_ce  in  1  asynchronous CPU select for the 4-word register window.
- cpu_we  in  1  asynchronous CPU write strobe.
- cpu_addr  in  2  word select, CPU addr[2:1].
- cpu_dato  in  16  CPU write data.
- cpu_dati  out  16  register read data, combinational from cpu_addr.
- cpu_buf_wr_en  out  1  enable for CPU writes into the dual-port buffer (1 = CPU owns buffer).
- mcu_irq  out  1  level; a command is pending acknowledge.
- mcu_cmd  out  8  latched command code.
- mcu_len  out  14  latched byte count.
- mcu_abort  out  1  one-cycle pulse on CPU abort.
- mcu_ack  in  1  pulse; MCU has taken the command.
- mcu_done  in  1  pulse; MCU has finished.
- mcu_resp  in  8  response code, sampled with mcu_done.
- mcu_err  in  1  error flag, sampled with mcu_done.

Behaviour:
- CPU strobe sync:
  - Sample cpu_ce&cpu_we into a 3-bit shift register on clk.
  - A write event is the pattern 'b011 (rising edge after 2 sync stages): exactly one cycle per CPU write.
  - cpu_addr and cpu_dato are captured on that event cycle.
- Registers, by cpu_addr:
  - 0 CMD (write): [7:0] code with doorbell; bit15=1 means abort (code ignored).
  - 1 STATUS (read): [0] busy (PEND|BUSY), [1] done, [2] err, [3] timeout, [4] overrun, [15:8] resp.
  - 2 LEN (read/write): [13:0]; a value above BUF_BYTES stores BUF_BYTES.
  - 3 reads 0x4D42; writes are ignored.
- FSM states: IDLE, PEND, BUSY, DONE. Reset state is IDLE.
- Reset values: cpu_buf_wr_en=1, mcu_irq=0, mcu_cmd=0, mcu_len=0, mcu_abort=0; LEN=0, all STATUS fields 0, timeout counter 0.
- IDLE or DONE + doorbell:
  - Latch mcu_cmd/mcu_len from code/LEN.
  - Clear done, err, timeout, overrun and resp.
  - Go to PEND. cpu_buf_wr_en falls on the same edge.
- PEND:
  - mcu_irq=1.
  - mcu_ack -> BUSY, and mcu_irq drops next cycle.
- BUSY: mcu_done -> DONE; resp<=mcu_resp, err<=mcu_err, done<=1; cpu_buf_wr_en rises.
- Timeout:
  - The counter clears on PEND entry and increments in PEND and BUSY.
  - When it reaches TIMEOUT_CYC-1: go to DONE with timeout=1, err=1, resp=0xFF.
  - If mcu_done arrives in the same cycle, mcu_done wins and timeout stays 0.
- Abort (CMD write with bit15), from any state:
  - Go to IDLE, clear all STATUS fields, set cpu_buf_wr_en=1.
  - Pulse mcu_abort for 1 cycle, but only if the state was PEND or BUSY.
  - Abort takes priority over mcu_done/mcu_ack/timeout in the same cycle.
- Protocol violations:
  - Doorbell in PEND/BUSY is ignored and sets sticky overrun; mcu_cmd/mcu_len are unchanged.
  - LEN write in PEND/BUSY is ignored.
  - mcu_ack outside PEND and mcu_done outside BUSY are ignored.
  - mcu_ack and mcu_done in the same PEND cycle: take ack only.
- Reset asserted mid-command returns to IDLE/reset values; mcu_abort is not pulsed.

Test Plan:
- Normal command: LEN=0x0100, CMD=0x12 -> PEND within 3 clk of the strobe; mcu_irq=1, cpu_buf_wr_en=0, mcu_cmd=0x12, mcu_len=0x100. Then ack, then done(resp 0x5A, err 0) -> STATUS=0x5A02, cpu_buf_wr_en=1.
- Timeout: TIMEOUT_CYC=16, doorbell, no ack -> DONE exactly 16 cycles after PEND entry; STATUS=0xFF0E.
- Done/timeout collision: TIMEOUT_CYC=16, ack, then done pulsed on the final counter cycle with resp 0x33 -> STATUS=0x3302, timeout=0.
- Overrun and abort:
  - Second doorbell while BUSY -> STATUS bit4=1, mcu_cmd unchanged.
  - Then CMD=0x8000 -> 1-cycle mcu_abort, IDLE, STATUS=0x0000, cpu_buf_wr_en=1.
- Clamp and sync:
  - LEN write 0x3FFF -> reads 8192 (0x2000).
  - cpu_ce&cpu_we held high for 10 clk -> exactly one write event.
  - Register 3 reads 0x4D42.
- Reset mid-BUSY: rst_n low 1 cycle -> all outputs at reset values, no mcu_abort pulse.

Source files
------------

// File: rtl/ramdp_mbox_ctrl.sv
// Mailbox controller that arbitrates ownership of the MCU/CPU dual-port buffer.
// The CPU rings a doorbell, the MCU acks and completes, and the buffer is returned.
module ramdp_mbox_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 50000000,
  parameter int unsigned TO_W        = 26,
  parameter int unsigned BUF_BYTES   = 8192
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_ce,
  input  logic        i_cpu_we,
  input  logic [1:0]  i_cpu_addr,
  input  logic [15:0] i_cpu_dato,
  output logic [15:0] o_cpu_dati,
  output logic        o_cpu_buf_wr_en,
  output logic        o_mcu_irq,
  output logic [7:0]  o_mcu_cmd,
  output logic [13:0] o_mcu_len,
  output logic        o_mcu_abort,
  input  logic        i_mcu_ack,
  input  logic        i_mcu_done,
  input  logic [7:0]  i_mcu_resp,
  input  logic        i_mcu_err
);

  typedef enum logic [1:0] {StIdle, StPend, StBusy, StDone} state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [13:0]     LEN_MAX = 14'(BUF_BYTES);

  state_e            r_state;
  logic [2:0]        r_sync;
  logic [TO_W-1:0]   r_cnt;
  logic [13:0]       r_len;
  logic              r_done;
  logic              r_err;
  logic              r_to;
  logic              r_ovr;
  logic [7:0]        r_resp;
  logic              r_buf_wr_en;
  logic              r_irq;
  logic [7:0]        r_cmd;
  logic [13:0]       r_mcu_len;
  logic              r_abort;

  logic              w_wr_ev;
  logic              w_doorbell;
  logic              w_abort;
  logic              w_len_wr;
  logic              w_active;
  logic              w_to_hit;
  logic [13:0]       w_len_clamp;

  // Rising edge of the strobe after two synchroniser stages: one event per CPU write
  assign w_wr_ev     = (r_sync == 3'b011);
  assign w_doorbell  = w_wr_ev && (i_cpu_addr == 2'd0) && !i_cpu_dato[15];
  assign w_abort     = w_wr_ev && (i_cpu_addr == 2'd0) && i_cpu_dato[15];
  assign w_len_wr    = w_wr_ev && (i_cpu_addr == 2'd2);
  assign w_active    = (r_state == StPend) || (r_state == StBusy);
  assign w_to_hit    = (TIMEOUT_CYC != 0) && w_active && (r_cnt == TO_LAST);
  assign w_len_clamp = (i_cpu_dato[13:0] > LEN_MAX) ? LEN_MAX : i_cpu_dato[13:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_sync      <= 3'b000;
      r_cnt       <= '0;
      r_len       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_to        <= 1'b0;
      r_ovr       <= 1'b0;
      r_resp      <= 8'h00;
      r_buf_wr_en <= 1'b1;
      r_irq       <= 1'b0;
      r_cmd       <= 8'h00;
      r_mcu_len   <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_sync  <= {r_sync[1:0], i_cpu_ce & i_cpu_we};
      r_abort <= 1'b0;
      if (w_active) r_cnt <= r_cnt + TO_W'(1);
      if (w_len_wr && !w_active) r_len <= w_len_clamp;

      if (w_abort) begin
        r_state     <= StIdle;
        r_done      <= 1'b0;
        r_err       <= 1'b0;
        r_to        <= 1'b0;
        r_ovr       <= 1'b0;
        r_resp      <= 8'h00;
        r_buf_wr_en <= 1'b1;
        r_irq       <= 1'b0;
        r_abort     <= w_active;
      end else begin
        if (w_doorbell && w_active) r_ovr <= 1'b1;
        case (r_state)
          StIdle, StDone: begin
            if (w_doorbell) begin
              r_cmd       <= i_cpu_dato[7:0];
              r_mcu_len   <= r_len;
              r_done      <= 1'b0;
              r_err       <= 1'b0;
              r_to        <= 1'b0;
              r_ovr       <= 1'b0;
              r_resp      <= 8'h00;
              r_cnt       <= '0;
              r_buf_wr_en <= 1'b0;
              r_irq       <= 1'b1;
              r_state     <= StPend;
            end
          end
          StPend: begin
            // Timeout beats a late ack so the counter cannot run past its limit
            if (w_to_hit) begin
              r_state     <= StDone;
              r_to        <= 1'b1;
              r_err       <= 1'b1;
              r_done      <= 1'b1;
              r_resp      <= 8'hFF;
              r_buf_wr_en <= 1'b1;
              r_irq       <= 1'b0;
            end else if (i_mcu_ack) begin
              r_state <= StBusy;
              r_irq   <= 1'b0;
            end
          end
          StBusy: begin
            if (i_mcu_done) begin
              r_state     <= StDone;
              r_resp      <= i_mcu_resp;
              r_err       <= i_mcu_err;
              r_done      <= 1'b1;
              r_buf_wr_en <= 1'b1;
            end else if (w_to_hit) begin
              r_state     <= StDone;
              r_to        <= 1'b1;
              r_err       <= 1'b1;
              r_done      <= 1'b1;
              r_resp      <= 8'hFF;
              r_buf_wr_en <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    o_cpu_dati = 16'h0000;
    case (i_cpu_addr)
      2'd1:    o_cpu_dati = {r_resp, 3'b000, r_ovr, r_to, r_err, r_done, w_active};
      2'd2:    o_cpu_dati = {2'b00, r_len};
      2'd3:    o_cpu_dati = 16'h4D42;
      default: o_cpu_dati = 16'h0000;
    endcase
  end

  assign o_cpu_buf_wr_en = r_buf_wr_en;
  assign o_mcu_irq       = r_irq;
  assign o_mcu_cmd       = r_cmd;
  assign o_mcu_len       = r_mcu_len;
  assign o_mcu_abort     = r_abort;

endmodule
